// File: rtl/bram_port_initiator.sv
// bram_port_initiator: turns a valid/ready request stream into single-port
// BRAM accesses and returns the read data on a valid/ready response stream.
// A 2-entry response buffer plus a credit check ensure that BRAM output
// data is never lost when the response side backpressures.
// Optional feature macro: BRAM_PORT_INITIATOR_WRITE_RESP_EN. When defined,
// writes also return a response (the write-first dout, acting as a write
// acknowledge) and are subject to the same credit limit as reads.
module bram_port_initiator #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_din,
    input  logic                  req_we,
    input  logic                  req_vld,
    output logic                  req_rd,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_vld,
    input  logic                  resp_rd,
    output logic [ADDR_WIDTH-1:0] port_addr,
    output logic [DATA_WIDTH-1:0] port_din,
    input  logic [DATA_WIDTH-1:0] port_dout,
    output logic                  port_en,
    output logic                  port_we
);

    logic                  inflight_q, inflight_d;
    logic [1:0]            occ_q, occ_d;
    logic                  wr_ptr_q, wr_ptr_d;
    logic                  rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] mem_q [2];
    logic [DATA_WIDTH-1:0] mem_d [2];

    logic       fire;
    logic       pop;
    logic       push;
    logic       credit_ok;
    logic       resp_expected;
    logic [2:0] credit_sum;

    assign resp_vld  = (occ_q != 2'd0);
    assign resp_data = mem_q[rd_ptr_q];

    // Request handshake, credit check and combinational BRAM port drive.
    always_comb begin
        pop        = resp_vld & resp_rd;
        // pop implies occ_q >= 1, so the subtraction cannot wrap.
        credit_sum = {2'b00, inflight_q} + {1'b0, occ_q} - {2'b00, pop};
        credit_ok  = (credit_sum < 3'd2);
`ifdef BRAM_PORT_INITIATOR_WRITE_RESP_EN
        req_rd        = !rst & credit_ok;
        fire          = req_vld & req_rd;
        resp_expected = fire;
`else
        req_rd        = !rst & (req_we | credit_ok);
        fire          = req_vld & req_rd;
        resp_expected = fire & !req_we;
`endif
        port_addr = req_addr;
        port_din  = req_din;
        port_en   = fire;
        port_we   = fire & req_we;
    end

    // Next-state for the in-flight flag and the response buffer.
    always_comb begin
        // port_dout is only meaningful the cycle after an access that wants a response.
        push       = inflight_q;
        inflight_d = resp_expected;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        occ_d      = occ_q;
        if (push) begin
            mem_d[wr_ptr_q] = port_dout;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase
    end

    // State registers; reset also drops any read still in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            mem_q      <= '{default: '0};
        end else begin
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            mem_q      <= mem_d;
        end
    end

endmodule

// File: tb/tb_bram_port_initiator.sv
// Directed bench for bram_port_initiator with a behavioural write-first BRAM.
module tb_bram_port_initiator;
    localparam int AW = 8;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_din;
    logic          req_we;
    logic          req_vld;
    logic          req_rd;
    logic [DW-1:0] resp_data;
    logic          resp_vld;
    logic          resp_rd;
    logic [AW-1:0] port_addr;
    logic [DW-1:0] port_din;
    logic [DW-1:0] port_dout;
    logic          port_en;
    logic          port_we;

    logic [DW-1:0] ram [256];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    bram_port_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req_addr(req_addr), .req_din(req_din), .req_we(req_we),
        .req_vld(req_vld), .req_rd(req_rd),
        .resp_data(resp_data), .resp_vld(resp_vld), .resp_rd(resp_rd),
        .port_addr(port_addr), .port_din(port_din), .port_dout(port_dout),
        .port_en(port_en), .port_we(port_we)
    );

    // Write-first BRAM port; drives a junk pattern whenever it is not enabled.
    always @(posedge clk) begin
        if (port_en) begin
            if (port_we) begin
                ram[port_addr] <= port_din;
                port_dout      <= port_din;
            end else begin
                port_dout <= ram[port_addr];
            end
        end else begin
            port_dout <= 64'hBAD0_BAD0_BAD0_BAD0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_vld  = vld;
        req_we   = we;
        req_addr = a;
        req_din  = d;
    endtask

    initial begin
        rst = 1'b1;
        resp_rd = 1'b1;
        drive(1'b1, 1'b0, 8'h00, 64'h0);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_req_rd", {63'd0, req_rd}, 64'd0);
        chk("rst_port_en", {63'd0, port_en}, 64'd0);
        chk("rst_port_we", {63'd0, port_we}, 64'd0);
        chk("rst_resp_vld", {63'd0, resp_vld}, 64'd0);
        chk("rst_resp_data", resp_data, 64'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 64'h0);
        tick();

`ifndef BRAM_PORT_INITIATOR_WRITE_RESP_EN
        // Write then read 0x05
        drive(1'b1, 1'b1, 8'h05, 64'h1122334455667788);
        @(negedge clk);
        chk("wr_req_rd", {63'd0, req_rd}, 64'd1);
        chk("wr_port_we", {63'd0, port_we}, 64'd1);
        tick();
        drive(1'b1, 1'b0, 8'h05, 64'h0);
        @(negedge clk);
        chk("rd_req_rd", {63'd0, req_rd}, 64'd1);
        chk("rd_port_en", {63'd0, port_en}, 64'd1);
        chk("rd_port_we", {63'd0, port_we}, 64'd0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 64'h0);
        @(negedge clk);
        chk("lat1_vld", {63'd0, resp_vld}, 64'd0);
        tick();
        @(negedge clk);
        chk("lat2_vld", {63'd0, resp_vld}, 64'd1);
        chk("lat2_data", resp_data, 64'h1122334455667788);
        tick();
        @(negedge clk);
        chk("popped_vld", {63'd0, resp_vld}, 64'd0);
        tick();

        // Fill 0x00..0x0F, then stream reads back to back
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, i[AW-1:0], 64'h100 + 64'(i));
            tick();
        end
        for (int c = 0; c < 18; c++) begin
            drive(c < 16, 1'b0, c[AW-1:0], 64'h0);
            @(negedge clk);
            if (c < 16) chk($sformatf("stream_req_rd_%0d", c), {63'd0, req_rd}, 64'd1);
            if (c >= 2) begin
                chk($sformatf("stream_vld_%0d", c - 2), {63'd0, resp_vld}, 64'd1);
                chk($sformatf("stream_data_%0d", c - 2), resp_data, 64'h100 + 64'(c - 2));
            end
            tick();
        end
        @(negedge clk);
        chk("stream_end_vld", {63'd0, resp_vld}, 64'd0);
        tick();

        // Backpressure: two reads accepted, writes still pass
        resp_rd = 1'b0;
        drive(1'b1, 1'b0, 8'h03, 64'h0);
        @(negedge clk);
        chk("bp_c0_req_rd", {63'd0, req_rd}, 64'd1);
        tick();
        drive(1'b1, 1'b0, 8'h04, 64'h0);
        @(negedge clk);
        chk("bp_c1_req_rd", {63'd0, req_rd}, 64'd1);
        tick();
        drive(1'b1, 1'b0, 8'h05, 64'h0);
        @(negedge clk);
        chk("bp_c2_req_rd", {63'd0, req_rd}, 64'd0);
        chk("bp_c2_data", resp_data, 64'h103);
        tick();
        @(negedge clk);
        chk("bp_c3_req_rd", {63'd0, req_rd}, 64'd0);
        chk("bp_c3_port_en", {63'd0, port_en}, 64'd0);
        chk("bp_c3_data", resp_data, 64'h103);
        tick();
        drive(1'b1, 1'b1, 8'h20, 64'h77);
        @(negedge clk);
        chk("bp_wr_req_rd", {63'd0, req_rd}, 64'd1);
        chk("bp_wr_port_en", {63'd0, port_en}, 64'd1);
        chk("bp_c4_data", resp_data, 64'h103);
        tick();
        drive(1'b1, 1'b0, 8'h05, 64'h0);
        @(negedge clk);
        chk("bp_c5_req_rd", {63'd0, req_rd}, 64'd0);
        chk("bp_c5_vld", {63'd0, resp_vld}, 64'd1);
        tick();
        resp_rd = 1'b1;
        @(negedge clk);
        chk("bp_resume_req_rd", {63'd0, req_rd}, 64'd1);
        chk("bp_resp0", resp_data, 64'h103);
        tick();
        drive(1'b0, 1'b0, 8'h00, 64'h0);
        @(negedge clk);
        chk("bp_resp1_vld", {63'd0, resp_vld}, 64'd1);
        chk("bp_resp1", resp_data, 64'h104);
        tick();
        @(negedge clk);
        chk("bp_resp2_vld", {63'd0, resp_vld}, 64'd1);
        chk("bp_resp2", resp_data, 64'h105);
        tick();
        @(negedge clk);
        chk("bp_end_vld", {63'd0, resp_vld}, 64'd0);
        tick();

        // Read-after-write on consecutive cycles
        drive(1'b1, 1'b1, 8'h30, 64'hAA);
        tick();
        drive(1'b1, 1'b0, 8'h30, 64'h0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 64'h0);
        @(negedge clk);
        chk("raw_lat1_vld", {63'd0, resp_vld}, 64'd0);
        tick();
        @(negedge clk);
        chk("raw_vld", {63'd0, resp_vld}, 64'd1);
        chk("raw_data", resp_data, 64'hAA);
        tick();

        // Reset the cycle after a read fire discards it
        drive(1'b1, 1'b1, 8'h31, 64'h5A5A_5A5A);
        tick();
        drive(1'b1, 1'b0, 8'h31, 64'h0);
        @(negedge clk);
        chk("rr_fire", {63'd0, req_rd}, 64'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("rr_rst_req_rd", {63'd0, req_rd}, 64'd0);
        chk("rr_rst_port_en", {63'd0, port_en}, 64'd0);
        tick();
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00, 64'h0);
        @(negedge clk);
        chk("rr_post_vld0", {63'd0, resp_vld}, 64'd0);
        tick();
        @(negedge clk);
        chk("rr_post_vld1", {63'd0, resp_vld}, 64'd0);
        chk("rr_post_data", resp_data, 64'd0);
        tick();
        drive(1'b1, 1'b0, 8'h31, 64'h0);
        tick();
        drive(1'b0, 1'b0, 8'h00, 64'h0);
        tick();
        @(negedge clk);
        chk("rr_reread_vld", {63'd0, resp_vld}, 64'd1);
        chk("rr_reread_data", resp_data, 64'h5A5A_5A5A);
        tick();
`else
        // Writes return their data as an acknowledge
        drive(1'b1, 1'b1, 8'h3C, 64'hDEAD);
        @(negedge clk);
        chk("wresp_req_rd", {63'd0, req_rd}, 64'd1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 64'h0);
        @(negedge clk);
        chk("wresp_lat1_vld", {63'd0, resp_vld}, 64'd0);
        tick();
        @(negedge clk);
        chk("wresp_vld", {63'd0, resp_vld}, 64'd1);
        chk("wresp_data", resp_data, 64'hDEAD);
        tick();
        @(negedge clk);
        chk("wresp_popped", {63'd0, resp_vld}, 64'd0);
        tick();

        // Writes stall after two outstanding acknowledges
        resp_rd = 1'b0;
        drive(1'b1, 1'b1, 8'h3D, 64'hD1);
        @(negedge clk);
        chk("wbp_c0_req_rd", {63'd0, req_rd}, 64'd1);
        tick();
        drive(1'b1, 1'b1, 8'h3E, 64'hD2);
        @(negedge clk);
        chk("wbp_c1_req_rd", {63'd0, req_rd}, 64'd1);
        tick();
        drive(1'b1, 1'b1, 8'h3F, 64'hD3);
        @(negedge clk);
        chk("wbp_c2_req_rd", {63'd0, req_rd}, 64'd0);
        tick();
        @(negedge clk);
        chk("wbp_c3_req_rd", {63'd0, req_rd}, 64'd0);
        chk("wbp_c3_data", resp_data, 64'hD1);
        tick();
        resp_rd = 1'b1;
        @(negedge clk);
        chk("wbp_resume_req_rd", {63'd0, req_rd}, 64'd1);
        chk("wbp_resp0", resp_data, 64'hD1);
        tick();
        drive(1'b0, 1'b0, 8'h00, 64'h0);
        @(negedge clk);
        chk("wbp_resp1", resp_data, 64'hD2);
        tick();
        @(negedge clk);
        chk("wbp_resp2_vld", {63'd0, resp_vld}, 64'd1);
        chk("wbp_resp2", resp_data, 64'hD3);
        tick();
        @(negedge clk);
        chk("wbp_end_vld", {63'd0, resp_vld}, 64'd0);
        tick();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
